bram_bank_loader: RTL and testbench

//  Write-side sequencer for the multi-bank BRAM weight/coefficient store. Accepts an AXI-Stream word stream and

---
 rtl/bram_bank_loader_pkg.sv | 24 ++
 rtl/bram_bank_loader_rr.sv | 51 +++++
 rtl/bram_bank_loader.sv | 153 +++++++++++++++
 tb/tb_bram_bank_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_bank_loader_pkg.sv
// Shared types and helpers for the BRAM bank loader: FSM encoding and the
// configuration legality check used when a load request is accepted.
package bram_bank_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width used for the legality arithmetic; wide enough that base + rows never overflows.
  localparam int unsigned CHK_W = 32;

  // A load fits when every row it touches lies inside the bank: base + ceil(words/banks) <= depth.
  function automatic logic cfg_legal(input logic [CHK_W-1:0] base,
                                     input logic [CHK_W-1:0] words,
                                     input logic [CHK_W-1:0] banks,
                                     input logic [CHK_W-1:0] depth);
    logic [CHK_W-1:0] rows;
    rows = (words + banks - 1) / banks;
    return (base + rows) <= depth;
  endfunction

endpackage

// File: rtl/bram_bank_loader_rr.sv
// Round-robin bank/address counter: word n goes to bank n%BANKS at base+n/BANKS.
// load restarts at (bank 0, base); adv steps one word, bumping the address on wrap.
module bank_rr_counter #(
  parameter int BANKS = 4,
  parameter int ADDR  = 8,
  parameter int BIDX  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_i,
  input  logic [ADDR-1:0] base_i,
  input  logic            adv_i,
  output logic [BIDX-1:0] bank_idx_o,
  output logic [ADDR-1:0] cur_addr_o
);

  logic [BIDX-1:0] bank_idx_q, bank_idx_d;
  logic [ADDR-1:0] cur_addr_q, cur_addr_d;

  // Next bank/address: load has priority over advance.
  always_comb begin
    bank_idx_d = bank_idx_q;
    cur_addr_d = cur_addr_q;
    if (load_i) begin
      bank_idx_d = '0;
      cur_addr_d = base_i;
    end else if (adv_i) begin
      if (bank_idx_q == BIDX'(BANKS - 1)) begin
        bank_idx_d = '0;
        cur_addr_d = cur_addr_q + ADDR'(1);
      end else begin
        bank_idx_d = bank_idx_q + BIDX'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_idx_q <= '0;
      cur_addr_q <= '0;
    end else begin
      bank_idx_q <= bank_idx_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  assign bank_idx_o = bank_idx_q;
  assign cur_addr_o = cur_addr_q;

endmodule

// File: rtl/bram_bank_loader.sv
// Write-side sequencer for the multi-bank weight store: scatters an AXI-Stream
// word stream round-robin across the port-A interfaces of BANKS BRAM banks.
module bram_bank_loader
  import bram_bank_loader_pkg::*;
#(
  parameter int BANKS = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int WE    = WIDTH / 8,
  parameter int CNT   = $clog2(BANKS * DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR-1:0]       cfg_base,
  input  logic [CNT-1:0]        cfg_words,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [BANKS-1:0]      ena,
  output logic [BANKS*WE-1:0]   wea,
  output logic [BANKS*ADDR-1:0] addra,
  output logic [BANKS*WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT-1:0]        words_written
);

  localparam int BIDX = (BANKS > 1) ? $clog2(BANKS) : 1;

  state_e               state_q, state_d;
  logic [CNT-1:0]       cfg_words_q, cfg_words_d;
  logic [CNT-1:0]       ww_q, ww_d;
  logic [CNT-1:0]       ww_inc;
  logic                 err_q, err_d;
  logic [BANKS-1:0]     ena_q, ena_d;
  logic [BANKS*WE-1:0]  wea_q, wea_d;
  logic [ADDR-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 hs, legal, cnt_load;
  logic [BIDX-1:0]      bank_idx;
  logic [ADDR-1:0]      cur_addr;

  assign legal         = cfg_legal(32'(cfg_base), 32'(cfg_words), 32'(BANKS), 32'(DEPTH));
  assign s_axis_tready = (state_q == ST_LOAD) & ~abort;
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign cnt_load      = (state_q == ST_IDLE) & start;
  assign ww_inc        = ww_q + CNT'(1);

  bank_rr_counter #(
    .BANKS (BANKS),
    .ADDR  (ADDR),
    .BIDX  (BIDX)
  ) u_rr (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (cnt_load),
    .base_i     (cfg_base),
    .adv_i      (hs),
    .bank_idx_o (bank_idx),
    .cur_addr_o (cur_addr)
  );

  // FSM next state, config latch, word count and error flag for the DONE cycle.
  always_comb begin
    state_d     = state_q;
    cfg_words_d = cfg_words_q;
    ww_d        = ww_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_words_d = cfg_words;
          ww_d        = '0;
          if (legal && (cfg_words != '0)) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
            err_d   = ~legal;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (hs) begin
          ww_d = ww_inc;
          if (ww_inc == cfg_words_q) begin
            state_d = ST_DONE;
            err_d   = ~s_axis_tlast;
          end else if (s_axis_tlast) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Port-A strobes for the word accepted this cycle; address/data hold between writes.
  always_comb begin
    ena_d  = '0;
    wea_d  = '0;
    addr_d = addr_q;
    data_d = data_q;
    if (hs) begin
      ena_d[bank_idx]            = 1'b1;
      wea_d[bank_idx*WE +: WE]   = '1;
      addr_d                     = cur_addr;
      data_d                     = s_axis_tdata;
    end
  end

  // State, status and port-A output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cfg_words_q <= '0;
      ww_q        <= '0;
      err_q       <= 1'b0;
      ena_q       <= '0;
      wea_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cfg_words_q <= cfg_words_d;
      ww_q        <= ww_d;
      err_q       <= err_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign ena           = ena_q;
  assign wea           = wea_q;
  assign addra         = {BANKS{addr_q}};
  assign dina          = {BANKS{data_q}};
  assign busy          = (state_q == ST_LOAD);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_bram_bank_loader.sv
// Directed bench for bram_bank_loader with BANKS=4, WIDTH=16, DEPTH=256.
module tb_bram_bank_loader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  cfg_base;
  logic [10:0] cfg_words;
  logic        abort;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [3:0]  ena;
  logic [7:0]  wea;
  logic [31:0] addra;
  logic [63:0] dina;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_written;

  int checks = 0;
  int errors = 0;

  bram_bank_loader #(.BANKS(4), .WIDTH(16), .DEPTH(256)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .cfg_base      (cfg_base),
    .cfg_words     (cfg_words),
    .abort         (abort),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .ena           (ena),
    .wea           (wea),
    .addra         (addra),
    .dina          (dina),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [10:0] words);
    start     = 1'b1;
    cfg_base  = base;
    cfg_words = words;
    tick();
    start     = 1'b0;
  endtask

  // Offer one word and check the port-A write it produces on the next cycle.
  task automatic word(input logic [15:0] d, input logic last, input int b, input logic [7:0] a);
    logic [3:0]  e_ena;
    logic [7:0]  e_wea;
    logic [31:0] e_addr;
    logic [63:0] e_din;
    e_ena  = 4'b0001 << b;
    e_wea  = 8'b0000_0011 << (2 * b);
    e_addr = {4{a}};
    e_din  = {4{d}};
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    #1;
    chk("tready", 128'(s_axis_tready), 128'(1));
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("ena", 128'(ena), 128'(e_ena));
    chk("wea", 128'(wea), 128'(e_wea));
    chk("addra", 128'(addra), 128'(e_addr));
    chk("dina", 128'(dina), 128'(e_din));
  endtask

  // One idle stream cycle: no strobes, address held.
  task automatic gap(input logic [7:0] a);
    logic [31:0] e_addr;
    e_addr = {4{a}};
    s_axis_tvalid = 1'b0;
    tick();
    chk("gap_ena", 128'(ena), 128'(0));
    chk("gap_wea", 128'(wea), 128'(0));
    chk("gap_addra_hold", 128'(addra), 128'(e_addr));
  endtask

  task automatic status(input string tag, input logic e_done, input logic e_err, input logic e_busy);
    chk({tag, "_done"}, 128'(done), 128'(e_done));
    chk({tag, "_err"}, 128'(err), 128'(e_err));
    chk({tag, "_busy"}, 128'(busy), 128'(e_busy));
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; cfg_base = '0; cfg_words = '0; abort = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    #2 rstn = 1'b0;
    #2;
    chk("rst_ena", 128'(ena), 128'(0));
    chk("rst_wea", 128'(wea), 128'(0));
    chk("rst_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_ww", 128'(words_written), 128'(0));
    status("rst", 1'b0, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    tick();

    // Eight words from base 0, continuous stream.
    start_load(8'd0, 11'd8);
    chk("t1_busy", 128'(busy), 128'(1));
    for (int k = 0; k < 8; k++) word(16'hA000 + 16'(k), k == 7, k % 4, 8'(k / 4));
    status("t1_end", 1'b1, 1'b0, 1'b0);
    chk("t1_ww", 128'(words_written), 128'(8));
    chk("t1_tready_done", 128'(s_axis_tready), 128'(0));
    tick();
    status("t1_idle", 1'b0, 1'b0, 1'b0);
    chk("t1_ena_idle", 128'(ena), 128'(0));

    // Six words from base 10 with a gap after each word.
    start_load(8'd10, 11'd6);
    for (int k = 0; k < 6; k++) begin
      word(16'h1100 + 16'(k), k == 5, k % 4, 8'(10 + k / 4));
      if (k < 5) gap(8'(10 + k / 4));
    end
    status("t2_end", 1'b1, 1'b0, 1'b0);
    chk("t2_ww", 128'(words_written), 128'(6));
    tick();

    // Illegal config: 28 words need 7 rows from 250 (> 256).
    s_axis_tvalid = 1'b1;
    start_load(8'd250, 11'd28);
    status("t3", 1'b1, 1'b1, 1'b0);
    chk("t3_ena", 128'(ena), 128'(0));
    chk("t3_tready", 128'(s_axis_tready), 128'(0));
    tick();
    status("t3_idle", 1'b0, 1'b0, 1'b0);
    chk("t3_ena_idle", 128'(ena), 128'(0));
    s_axis_tvalid = 1'b0;

    // Zero-word load completes immediately without error.
    start_load(8'd0, 11'd0);
    status("t0w", 1'b1, 1'b0, 1'b0);
    tick();

    // Early tlast on the fifth of eight words.
    start_load(8'd0, 11'd8);
    for (int k = 0; k < 5; k++) word(16'h2200 + 16'(k), k == 4, k % 4, 8'(k / 4));
    status("t4_end", 1'b1, 1'b1, 1'b0);
    chk("t4_ww", 128'(words_written), 128'(5));
    tick();

    // Abort after three words, with a new start asserted during the load.
    start_load(8'd0, 11'd8);
    for (int k = 0; k < 3; k++) word(16'h3300 + 16'(k), 1'b0, k, 8'd0);
    abort = 1'b1; s_axis_tvalid = 1'b1; start = 1'b1; cfg_base = 8'd50; cfg_words = 11'd2;
    #1;
    chk("t5_tready_abort", 128'(s_axis_tready), 128'(0));
    tick();
    abort = 1'b0; start = 1'b0; s_axis_tvalid = 1'b0;
    chk("t5_ena", 128'(ena), 128'(0));
    status("t5_end", 1'b1, 1'b1, 1'b0);
    chk("t5_ww", 128'(words_written), 128'(3));
    tick();
    status("t5_idle", 1'b0, 1'b0, 1'b0);
    chk("t5_ww_hold", 128'(words_written), 128'(3));

    // Asynchronous reset mid-load, then reload from a new base.
    start_load(8'd0, 11'd8);
    word(16'h4400, 1'b0, 0, 8'd0);
    word(16'h4401, 1'b0, 1, 8'd0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_ena", 128'(ena), 128'(0));
    chk("t6_wea", 128'(wea), 128'(0));
    chk("t6_addra", 128'(addra), 128'(0));
    chk("t6_dina", 128'(dina), 128'(0));
    chk("t6_ww", 128'(words_written), 128'(0));
    chk("t6_tready", 128'(s_axis_tready), 128'(0));
    status("t6_rst", 1'b0, 1'b0, 1'b0);
    #3 rstn = 1'b1;
    tick();
    start_load(8'd20, 11'd4);
    for (int k = 0; k < 4; k++) word(16'h5500 + 16'(k), k == 3, k, 8'd20);
    status("t6_end", 1'b1, 1'b0, 1'b0);
    chk("t6_ww_end", 128'(words_written), 128'(4));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
